cdm_err_stats: RTL

Streaming error-metric accumulator placed directly downstream of the 8x8 carry-disregard approximate multipliers. Each accepted beat carries the operands and the approximate product. The block computes the exact product, the error distance (ED) and the signed error, and accumulates the totals over a fixed-length sweep. When the sweep completes it presents the results for characterisation runs (MED, error rate, worst-case ED).

---
 rtl/cdm_err_stats.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cdm_err_stats.sv
// Error-metric accumulator for an 8x8 carry-disregard approximate multiplier sweep.
// Latency: beat accepted at edge k lands in the accumulators after edge k+2; done 2 cycles after the last accept.
// Backpressure: in_ready is high only in RUN; no internal stall, one beat per cycle while RUN.
//
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   start                      - begin a sweep (honoured in IDLE/DONE only)
//   in_valid/in_ready          - beat handshake; in_a, in_b operands, in_r approximate product
//   busy, done                 - sweep in progress / results final and stable
//   sample_cnt, err_cnt        - beats accepted / beats with in_r != in_a*in_b
//   max_ed, sum_ed, sum_sed    - worst-case ED, sum of ED, signed sum of (exact - approx)
module cdm_err_stats #(
  parameter int W         = 8,
  parameter int N_SAMPLES = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2*W-1:0]   in_r,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     sample_cnt,
  output logic [2*W:0]     err_cnt,
  output logic [2*W-1:0]   max_ed,
  output logic [4*W-1:0]   sum_ed,
  output logic [4*W:0]     sum_sed
);

  localparam int CW = 2*W + 1;
  localparam logic [CW-1:0] N_LAST = CW'(N_SAMPLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            drain_q, drain_d;

  // Stage 1: exact product and approximate product.
  logic [2*W-1:0]  p1_q, r1_q;
  logic            v1_q;
  // Stage 2: signed difference and its magnitude.
  logic [2*W:0]    d2_q, d2_d;
  logic [2*W-1:0]  ed2_q, ed2_d;
  logic            v2_q;

  logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic [2*W-1:0]  max_ed_q, max_ed_d;
  logic [4*W-1:0]  sum_ed_q, sum_ed_d;
  logic [4*W:0]    sum_sed_q, sum_sed_d;

  logic            accept;
  logic            restart;
  logic [2*W:0]    neg_d;

  assign accept  = in_valid && (state_q == S_RUN);
  assign restart = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // FSM next state.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && (sample_cnt_q + CW'(1) == N_LAST)) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        // Two flush cycles: the last beat needs stage 2 plus the accumulate edge.
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Difference is formed as a (2W+1)-bit two's-complement value so the sign survives.
  always_comb begin
    d2_d  = {1'b0, p1_q} - {1'b0, r1_q};
    neg_d = -d2_d;
    ed2_d = d2_d[2*W] ? neg_d[2*W-1:0] : d2_d[2*W-1:0];
  end

  // Counters and accumulators; a honoured start clears them on the same edge.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    max_ed_d     = max_ed_q;
    sum_ed_d     = sum_ed_q;
    sum_sed_d    = sum_sed_q;
    if (restart) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      max_ed_d     = '0;
      sum_ed_d     = '0;
      sum_sed_d    = '0;
    end else begin
      if (accept) sample_cnt_d = sample_cnt_q + CW'(1);
      if (v2_q) begin
        sum_ed_d  = sum_ed_q + {{(2*W){1'b0}}, ed2_q};
        sum_sed_d = sum_sed_q + {{(2*W){d2_q[2*W]}}, d2_q};
        err_cnt_d = err_cnt_q + CW'(d2_q != '0);
        if (ed2_q > max_ed_q) max_ed_d = ed2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drain_q      <= 1'b0;
      p1_q         <= '0;
      r1_q         <= '0;
      v1_q         <= 1'b0;
      d2_q         <= '0;
      ed2_q        <= '0;
      v2_q         <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
      sum_sed_q    <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      v1_q         <= accept && !restart;
      v2_q         <= v1_q && !restart;
      if (accept) begin
        p1_q <= in_a * in_b;
        r1_q <= in_r;
      end
      if (v1_q) begin
        d2_q  <= d2_d;
        ed2_q <= ed2_d;
      end
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_ed_q     <= max_ed_d;
      sum_ed_q     <= sum_ed_d;
      sum_sed_q    <= sum_sed_d;
    end
  end

  assign in_ready   = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign max_ed     = max_ed_q;
  assign sum_ed     = sum_ed_q;
  assign sum_sed    = sum_sed_q;

endmodule
